// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and scoreboard types used by the ID-stage
// hazard logic.
package mips_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;

  localparam reg_idx_t REG_RA = 5'd31;

  typedef struct packed {
    logic     valid;
    reg_idx_t addr;
    logic     is_load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, addr: 5'd0, is_load: 1'b0};

  // $0 is hardwired, so it can never create a dependency.
  function automatic logic entry_hit(sb_entry_t e, reg_idx_t src, logic src_en);
    return src_en & (src != 5'd0) & e.valid & (e.addr == src);
  endfunction

endpackage

// File: rtl/inst_regdecode.sv
// Combinational register-usage decode of one MIPS instruction: which
// registers it reads as operands A/B, which it writes, and whether it is a load.
module inst_regdecode
  import mips_pkg::*;
(
  input  logic [31:0] id_inst,
  output logic [4:0]  src_a,
  output logic        src_a_en,
  output logic [4:0]  src_b,
  output logic        src_b_en,
  output logic [4:0]  dest,
  output logic        dest_en,
  output logic        is_load
);

  logic [5:0] opcode;
  logic [5:0] func;
  reg_idx_t   rs;
  reg_idx_t   rt;
  reg_idx_t   rd;
  logic       unused_shamt;

  assign opcode       = id_inst[31:26];
  assign rs           = id_inst[25:21];
  assign rt           = id_inst[20:16];
  assign rd           = id_inst[15:11];
  assign func         = id_inst[5:0];
  assign unused_shamt = ^id_inst[10:6];

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    src_a    = 5'd0;
    src_a_en = 1'b0;
    src_b    = 5'd0;
    src_b_en = 1'b0;
    dest     = 5'd0;
    dest_en  = 1'b0;
    is_load  = 1'b0;

    case (opcode)
      OP_SPECIAL: begin
        case (func)
          FN_SLL, FN_SRL: begin
            src_a    = rt;
            src_a_en = 1'b1;
            dest     = rd;
            dest_en  = 1'b1;
          end
          FN_JR: begin
            src_a    = rs;
            src_a_en = 1'b1;
          end
          default: begin
            src_a    = rs;
            src_a_en = 1'b1;
            src_b    = rt;
            src_b_en = 1'b1;
            dest     = rd;
            dest_en  = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_SLTI, OP_LW: begin
        src_a    = rs;
        src_a_en = 1'b1;
        dest     = rt;
        dest_en  = 1'b1;
        is_load  = (opcode == OP_LW);
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        src_a    = rs;
        src_a_en = 1'b1;
        src_b    = rt;
        src_b_en = 1'b1;
      end
      OP_JAL: begin
        dest    = REG_RA;
        dest_en = 1'b1;
      end
      default: ;  // J and unknown opcodes touch no registers
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detection: shift scoreboard of in-flight register writes
// (entry 1 = EXE .. entry DEPTH = WB), stall/forward generation, stall counter.
module hazard_scoreboard
  import mips_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter bit FWD_EN = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                id_inst,
  input  logic                       id_valid,
  input  logic                       flush,
  output logic                       stall,
  output logic [$clog2(DEPTH+1)-1:0] fwd_a,
  output logic [$clog2(DEPTH+1)-1:0] fwd_b,
  output logic [CNT_W-1:0]           stall_count
);

  localparam int FW = $clog2(DEPTH+1);

  logic [4:0] src_a, src_b, dest;
  logic       src_a_en, src_b_en, dest_en, is_load;

  inst_regdecode u_decode (
    .id_inst  (id_inst),
    .src_a    (src_a),
    .src_a_en (src_a_en),
    .src_b    (src_b),
    .src_b_en (src_b_en),
    .dest     (dest),
    .dest_en  (dest_en),
    .is_load  (is_load)
  );

  sb_entry_t [DEPTH:1] sb_q, sb_d;
  logic [DEPTH:1]      hit_a, hit_b;
  logic [FW-1:0]       sel_a, sel_b;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                active, raw_stall, issue, dest_act;
  logic                unused_sb;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_match
    assign hit_a[k] = entry_hit(sb_q[k], src_a, src_a_en);
    assign hit_b[k] = entry_hit(sb_q[k], src_b, src_b_en);
  end

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (hit_a[k]) sel_a = FW'(k);
      if (hit_b[k]) sel_b = FW'(k);
    end
  end

  assign active = id_valid & ~flush;

  always_comb begin
    if (FWD_EN) raw_stall = sb_q[1].is_load & (hit_a[1] | hit_b[1]);
    else        raw_stall = (|hit_a) | (|hit_b);
  end

  assign stall = active & raw_stall;
  assign fwd_a = (FWD_EN && active && !raw_stall) ? sel_a : '0;
  assign fwd_b = (FWD_EN && active && !raw_stall) ? sel_b : '0;

  assign issue    = active & ~raw_stall;
  assign dest_act = dest_en & (dest != 5'd0);

  always_comb begin
    sb_d = sb_q;
    for (int k = DEPTH; k >= 2; k--) sb_d[k] = sb_q[k-1];
    if (issue && dest_act) sb_d[1] = '{valid: 1'b1, addr: dest, is_load: is_load};
    else                   sb_d[1] = SB_BUBBLE;
  end

  assign cnt_d = (stall && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk) begin
    // NOTE: all scoreboard entries are reset; a stale valid bit would fake a hazard.
    if (rst) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;
  assign unused_sb   = ^sb_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: four scoreboard configurations share one stimulus
// stream and are compared against an in-flight-write list model.
module tb_hazard_scoreboard;

  localparam int N = 4;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_JR = 6'h08, F_SLL = 6'h00;

  int depth_of [N] = '{3, 3, 3, 5};
  bit fwd_of   [N] = '{0, 1, 0, 1};
  int cmax_of  [N] = '{65535, 65535, 15, 255};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] id_inst = '0;
  logic        id_valid = 1'b0;
  logic        flush = 1'b0;

  logic        st0, st1, st2, st3;
  logic [1:0]  fa0, fb0, fa1, fb1, fa2, fb2;
  logic [2:0]  fa3, fb3;
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;
  logic [7:0]  sc3;

  logic        st [N];
  logic [3:0]  fa [N];
  logic [3:0]  fb [N];
  logic [15:0] sc [N];

  assign st[0] = st0; assign st[1] = st1; assign st[2] = st2; assign st[3] = st3;
  assign fa[0] = {2'b0, fa0}; assign fa[1] = {2'b0, fa1};
  assign fa[2] = {2'b0, fa2}; assign fa[3] = {1'b0, fa3};
  assign fb[0] = {2'b0, fb0}; assign fb[1] = {2'b0, fb1};
  assign fb[2] = {2'b0, fb2}; assign fb[3] = {1'b0, fb3};
  assign sc[0] = sc0; assign sc[1] = sc1;
  assign sc[2] = {12'b0, sc2}; assign sc[3] = {8'b0, sc3};

  hazard_scoreboard #(.DEPTH(3), .FWD_EN(1'b0), .CNT_W(16)) u_d0 (
    .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid), .flush(flush),
    .stall(st0), .fwd_a(fa0), .fwd_b(fb0), .stall_count(sc0));
  hazard_scoreboard #(.DEPTH(3), .FWD_EN(1'b1), .CNT_W(16)) u_d1 (
    .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid), .flush(flush),
    .stall(st1), .fwd_a(fa1), .fwd_b(fb1), .stall_count(sc1));
  hazard_scoreboard #(.DEPTH(3), .FWD_EN(1'b0), .CNT_W(4)) u_d2 (
    .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid), .flush(flush),
    .stall(st2), .fwd_a(fa2), .fwd_b(fb2), .stall_count(sc2));
  hazard_scoreboard #(.DEPTH(5), .FWD_EN(1'b1), .CNT_W(8)) u_d3 (
    .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid), .flush(flush),
    .stall(st3), .fwd_a(fa3), .fwd_b(fb3), .stall_count(sc3));

  always #5 clk = ~clk;

  // Model: per configuration, the register written by the instruction that is
  // age cycles past ID (0 = nothing written), plus whether it is a load.
  int m_reg [N][1:8];
  bit m_ld  [N][1:8];
  int m_cnt [N];
  bit exp_stall [N];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] R(input int rs, input int rt, input int rd, input logic [5:0] fn);
    logic [4:0] s, t, d;
    s = 5'(rs); t = 5'(rt); d = 5'(rd);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] I(input logic [5:0] op, input int rs, input int rt, input int imm);
    logic [4:0] s, t;
    logic [15:0] m;
    s = 5'(rs); t = 5'(rt); m = 16'(imm);
    return {op, s, t, m};
  endfunction

  // Register usage of an instruction; 0 means "none" since $0 never matters.
  task automatic ref_decode(input logic [31:0] ins, output int ra, output int rb,
                            output int rd, output bit ld);
    int op, fn, rs, rt, rdf;
    op = int'(ins[31:26]); fn = int'(ins[5:0]);
    rs = int'(ins[25:21]); rt = int'(ins[20:16]); rdf = int'(ins[15:11]);
    ra = 0; rb = 0; rd = 0; ld = 0;
    if (op == 0) begin
      if (fn == 0 || fn == 2)  begin ra = rt; rd = rdf; end
      else if (fn == 8)        ra = rs;
      else                     begin ra = rs; rb = rt; rd = rdf; end
    end else if (op == 8 || op == 10 || op == 35) begin
      ra = rs; rd = rt; ld = (op == 35);
    end else if (op == 43 || op == 4 || op == 5) begin
      ra = rs; rb = rt;
    end else if (op == 3) begin
      rd = 31;
    end
  endtask

  task automatic model_eval(input int i, output bit s, output int a, output int b);
    int ra, rb, rd;
    bit ld;
    ref_decode(id_inst, ra, rb, rd, ld);
    s = 0; a = 0; b = 0;
    if (id_valid && !flush) begin
      for (int k = depth_of[i]; k >= 1; k--) begin
        if (ra != 0 && m_reg[i][k] == ra) a = k;
        if (rb != 0 && m_reg[i][k] == rb) b = k;
      end
      if (fwd_of[i]) s = m_ld[i][1] && (a == 1 || b == 1);
      else           s = (a != 0 || b != 0);
    end
    if (s || !fwd_of[i]) begin a = 0; b = 0; end
  endtask

  task automatic model_update();
    int ra, rb, rd;
    bit ld, iss;
    ref_decode(id_inst, ra, rb, rd, ld);
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        for (int k = 1; k <= 8; k++) begin m_reg[i][k] = 0; m_ld[i][k] = 0; end
        m_cnt[i] = 0;
      end else begin
        if (exp_stall[i] && m_cnt[i] < cmax_of[i]) m_cnt[i]++;
        for (int k = depth_of[i]; k >= 2; k--) begin
          m_reg[i][k] = m_reg[i][k-1];
          m_ld[i][k]  = m_ld[i][k-1];
        end
        iss = id_valid && !flush && !exp_stall[i];
        m_reg[i][1] = iss ? rd : 0;
        m_ld[i][1]  = iss && rd != 0 && ld;
      end
    end
  endtask

  // Drive one cycle's inputs and compare every configuration with the model.
  task automatic apply(input logic [31:0] ins, input bit v, input bit f, input bit r);
    id_inst = ins; id_valid = v; flush = f; rst = r;
    #2;
    for (int i = 0; i < N; i++) begin
      bit s;
      int a, b;
      model_eval(i, s, a, b);
      exp_stall[i] = s;
      check($sformatf("d%0d_stall", i), 32'(st[i]), 32'(s));
      if (!s) begin
        check($sformatf("d%0d_fwd_a", i), 32'(fa[i]), 32'(a));
        check($sformatf("d%0d_fwd_b", i), 32'(fb[i]), 32'(b));
      end
      check($sformatf("d%0d_count", i), 32'(sc[i]), 32'(m_cnt[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    apply(32'd0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  function automatic int rnd_reg();
    return ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 4));
  endfunction

  function automatic logic [31:0] rnd_inst();
    case ($urandom_range(0, 10))
      0:       return R(rnd_reg(), rnd_reg(), rnd_reg(), F_ADD);
      1:       return R(rnd_reg(), rnd_reg(), rnd_reg(), F_SUB);
      2:       return R(0, rnd_reg(), rnd_reg(), F_SLL);
      3:       return R(rnd_reg(), 0, 0, F_JR);
      4:       return I(6'h08, rnd_reg(), rnd_reg(), 1);
      5:       return I(6'h23, rnd_reg(), rnd_reg(), 4);
      6:       return I(6'h23, rnd_reg(), rnd_reg(), 0);
      7:       return I(6'h2B, rnd_reg(), rnd_reg(), 8);
      8:       return I(6'h04, rnd_reg(), rnd_reg(), 2);
      9:       return {6'h03, 26'h10};
      default: return {6'h3F, 26'($urandom())};
    endcase
  endfunction

  logic [31:0] add2, sub6, add3, lw7, add9, jr31;

  initial begin
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      exp_stall[i] = 0;
      for (int k = 1; k <= 8; k++) begin m_reg[i][k] = 0; m_ld[i][k] = 0; end
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    apply(32'd0, 1'b0, 1'b0, 1'b0);
    check("reset_stall", 32'(st[0]), 32'd0);
    check("reset_count", 32'(sc[0]), 32'd0);
    tick();

    // Full interlock RAW: 3 stall cycles at DEPTH=3
    add2 = R(1, 1, 2, F_ADD);
    apply(I(6'h08, 0, 1, 5), 1'b1, 1'b0, 1'b0); tick();
    for (int c = 0; c < 4; c++) begin
      apply(add2, 1'b1, 1'b0, 1'b0);
      check($sformatf("raw_stall_c%0d", c), 32'(st[0]), (c < 3) ? 32'd1 : 32'd0);
      tick();
    end
    apply(32'd0, 1'b0, 1'b0, 1'b0);
    check("raw_count", 32'(sc[0]), 32'd3);
    check("raw_count_w4", 32'(sc[2]), 32'd3);
    tick();

    // Forwarding from entry 1, then entry 2
    do_reset();
    add3 = R(4, 5, 3, F_ADD);
    sub6 = R(3, 3, 6, F_SUB);
    apply(add3, 1'b1, 1'b0, 1'b0); tick();
    apply(sub6, 1'b1, 1'b0, 1'b0);
    check("fwd1_stall", 32'(st[1]), 32'd0);
    check("fwd1_a", 32'(fa[1]), 32'd1);
    check("fwd1_b", 32'(fb[1]), 32'd1);
    check("fwd1_a_d5", 32'(fa[3]), 32'd1);
    tick();
    apply(add3, 1'b1, 1'b0, 1'b0); tick();
    apply(I(6'h08, 0, 10, 1), 1'b1, 1'b0, 1'b0); tick();
    apply(sub6, 1'b1, 1'b0, 1'b0);
    check("fwd2_a", 32'(fa[1]), 32'd2);
    check("fwd2_b", 32'(fb[1]), 32'd2);
    tick();

    // Load-use: exactly one stall, then forward from entry 2
    do_reset();
    lw7  = I(6'h23, 8, 7, 0);
    add9 = R(7, 0, 9, F_ADD);
    apply(lw7, 1'b1, 1'b0, 1'b0); tick();
    apply(add9, 1'b1, 1'b0, 1'b0);
    check("lu_stall_c0", 32'(st[1]), 32'd1);
    tick();
    apply(add9, 1'b1, 1'b0, 1'b0);
    check("lu_stall_c1", 32'(st[1]), 32'd0);
    check("lu_fwd_a", 32'(fa[1]), 32'd2);
    check("lu_fwd_b", 32'(fb[1]), 32'd0);
    tick();

    // $0 writes are ignored; JAL creates a write to $31
    do_reset();
    apply(I(6'h08, 0, 0, 1), 1'b1, 1'b0, 1'b0); tick();
    apply(R(0, 0, 2, F_ADD), 1'b1, 1'b0, 1'b0);
    check("r0_stall", 32'(st[0]), 32'd0);
    check("r0_fwd_a", 32'(fa[1]), 32'd0);
    check("r0_fwd_b", 32'(fb[1]), 32'd0);
    tick();
    jr31 = R(31, 0, 0, F_JR);
    apply({6'h03, 26'h40}, 1'b1, 1'b0, 1'b0); tick();
    apply({6'h02, 26'h80}, 1'b1, 1'b0, 1'b0); tick();
    apply(jr31, 1'b1, 1'b0, 1'b0);
    check("jal_stall", 32'(st[0]), 32'd1);
    check("jal_fwd_a", 32'(fa[1]), 32'd2);
    tick();

    // Flush beats hazard and inserts a bubble
    do_reset();
    apply(I(6'h08, 0, 1, 5), 1'b1, 1'b0, 1'b0); tick();
    apply(add2, 1'b1, 1'b1, 1'b0);
    check("flush_stall", 32'(st[0]), 32'd0);
    check("flush_fwd_a", 32'(fa[1]), 32'd0);
    tick();
    apply(R(2, 2, 5, F_ADD), 1'b1, 1'b0, 1'b0);
    check("flush_bubble_stall", 32'(st[0]), 32'd0);
    check("flush_bubble_fwd", 32'(fa[1]), 32'd0);
    tick();

    // Reset in the middle of a stall
    do_reset();
    apply(I(6'h08, 0, 1, 5), 1'b1, 1'b0, 1'b0); tick();
    apply(add2, 1'b1, 1'b0, 1'b0);
    check("mid_stall_before", 32'(st[0]), 32'd1);
    tick();
    apply(add2, 1'b1, 1'b0, 1'b1); tick();
    apply(add2, 1'b1, 1'b0, 1'b0);
    check("mid_stall_after", 32'(st[0]), 32'd0);
    check("mid_count_after", 32'(sc[0]), 32'd0);
    tick();

    // Saturation of the 4-bit counter
    do_reset();
    for (int r = 0; r < 8; r++) begin
      apply(I(6'h08, 0, 1, 5), 1'b1, 1'b0, 1'b0); tick();
      repeat (4) begin apply(add2, 1'b1, 1'b0, 1'b0); tick(); end
    end
    apply(32'd0, 1'b0, 1'b0, 1'b0);
    check("sat_count_w4", 32'(sc[2]), 32'd15);
    check("sat_count_w16", 32'(sc[0]), 32'd24);
    tick();

    // Randomized traffic, instructions sometimes held as a stalled ID would be
    begin
      logic [31:0] cur;
      cur = rnd_inst();
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 1) == 0) cur = rnd_inst();
        apply(cur, $urandom_range(0, 6) != 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 99) == 0);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard-detection and forwarding-control block for the pipelined MIPS core, sitting beside the ID stage. It decodes the ID instruction's source and destination registers and tracks every in-flight register write in an internal DEPTH-entry shift scoreboard (EXE..WB). From that state it generates the ID stall and per-operand forwarding selects. It supports two modes: full interlock, or forwarding with load-use stall only. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- DEPTH, 3: pipeline stages after ID up to and including register write (entry 1 = EXE, entry DEPTH = WB); legal 2..8
- FWD_EN, 0: 0 = stall on any pending write to a source; 1 = forward, stall only on load-use
- CNT_W, 16: stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- id_inst  in  32  instruction currently in ID
- id_valid  in  1  ID holds a real instruction
- flush  in  1  kill ID instruction this cycle (branch/jump redirect)
- stall  out  1  hold PC and IF/ID; inject bubble into EXE
- fwd_a  out  $clog2(DEPTH+1)  operand-A source: 0 = register file, k = entry k
- fwd_b  out  $clog2(DEPTH+1)  operand-B source, same encoding
- stall_count  out  CNT_W  cycles with stall=1 since reset, saturating

## Operation
- Decode:
  - opcode 0 with func SLL/SRL: reads rt as A; dest rd.
  - opcode 0 with func JR: reads rs as A; no dest.
  - Other opcode 0: reads rs (A) and rt (B); dest rd.
  - ADDI/SLTI/LW: reads rs (A); dest rt. LW is marked is_load.
  - SW/BEQ/BNE: reads rs (A) and rt (B); no dest.
  - J: no reads, no dest. JAL: no reads; dest 31.
  - Unknown opcode: no reads, no dest.
- Register 0 is never a source match and never a dest. A dest of 0 is recorded as no-write.
- Entry format: {valid, addr[4:0], is_load}.
- Issue condition: id_valid & ~flush & ~stall.
- Every cycle, entry k+1 <= entry k and entry DEPTH retires.
- Entry 1 <= decoded dest when issuing with a dest, else a bubble (valid=0).
- A match for a source is any valid entry whose addr equals that source.
- FWD_EN=0: stall = id_valid & ~flush & (any source matches any entry). fwd_a = fwd_b = 0 always.
- FWD_EN=1: stall = id_valid & ~flush & (a source matches entry 1 with is_load=1).
  - Otherwise fwd_x = index of the lowest-numbered (youngest) matching entry, or 0 if no match.
- With id_valid=0 or flush=1, stall=0 and fwd_a=fwd_b=0.
- stall_count increments when stall=1 and holds at all-ones.

## Timing
- stall, fwd_a, fwd_b are combinational from id_inst, id_valid, flush and registered scoreboard state. There is no added latency.
- Scoreboard and counter update on the rising clk edge.
- Reset (rst=1 at an edge): all entries invalid, stall_count=0. Outputs are therefore stall=0, fwd=0 in the cycle after reset.
- Reset mid-stall discards all in-flight entries; the next ID instruction issues unstalled.
- Bubbles keep shifting while stalled, so a FWD_EN=0 RAW stall resolves after exactly DEPTH-k+1 cycles for a producer in entry k.
  - Example: DEPTH=3, back-to-back dependent ADDs give 3 stall cycles.
- FWD_EN=1 load-use gives exactly 1 stall cycle.
- A simultaneous flush and hazard produces no stall; entry 1 gets a bubble.
- When one entry matches both sources, both fwd outputs select it.

## Structure
- Shared package mips_pkg: opcode/func constants (SLL, SRL, JR, ADDI, SLTI, LW, SW, BEQ, BNE, J, JAL), the scoreboard entry struct, and reg-index type.
- Sub-module inst_regdecode (combinational: id_inst -> src_a, src_a_en, src_b, src_b_en, dest, dest_en, is_load). It is reusable by the ID stage control.
- Top level holds the entry shift array, match/priority logic (generate loop over DEPTH), and the counter.

## Test plan
- FWD_EN=0, DEPTH=3: ADDI $1,$0,5 then ADD $2,$1,$1.
  - stall=1 for 3 cycles, then drops.
  - stall_count=3.
- FWD_EN=1: ADD $3,$4,$5 then SUB $6,$3,$3.
  - stall=0, fwd_a=fwd_b=1.
  - One cycle later with an independent instruction in between: fwd=2.
- FWD_EN=1: LW $7,0($8) then ADD $9,$7,$0.
  - stall=1 for exactly 1 cycle, then fwd_a=2, fwd_b=0.
- Writes to $0 (ADDI $0,$0,1) followed by reader of $0: no stall, fwd=0. J/JAL followed by JR $31 after JAL gives a match on 31.
- Dependent instruction with flush=1: stall=0, no entry inserted. rst asserted during a multi-cycle stall: next cycle stall=0, stall_count=0.
- CNT_W=4 with sustained stalls: stall_count saturates at 15.
